// File: rtl/ack_bus_pkg.sv
// rtl/ack_bus_pkg.sv - shared ack bus source IDs and error bit positions
package ack_bus_pkg;
    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;

    localparam int NUM_SRC = 4;

    localparam int ERR_SPUR = 0;
    localparam int ERR_OVF  = 1;
    localparam int ERR_SAT  = 2;
endpackage

// File: rtl/ack_evt_fifo.sv
// rtl/ack_evt_fifo.sv - show-ahead completion event fifo
module ack_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign head  = mem[rd_ptr];

    // A full fifo still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ack_bus_rx_tracker.sv
// rtl/ack_bus_rx_tracker.sv - ack bus sampler, per-source outstanding tracker and event queue
module ack_bus_rx_tracker
    import ack_bus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ack_valid_n_bus_i,
    input  logic [1:0]               ack_id_bus_i,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_id,
    output logic                     evt_valid,
    output logic [1:0]               evt_id,
    input  logic                     evt_ready,
    output logic [4*CNT_W-1:0]       pending_cnt,
    output logic                     busy,
    output logic [2:0]               err,
    input  logic                     err_clr
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s_vld;
    logic [1:0]       s_id;
    logic [CNT_W-1:0] cnt     [NUM_SRC];
    logic [CNT_W-1:0] cnt_nxt [NUM_SRC];
    logic             busy_nxt;
    logic             hit;
    logic             sat_err;
    logic             ovf_err;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [1:0]       fifo_head;
    logic [2:0]       err_set;

    // An ack is legitimate if something is outstanding or is being issued right now.
    assign hit = s_vld && ((cnt[s_id] != '0) || (issue_valid && (issue_id == s_id)));

    always_comb begin
        sat_err  = 1'b0;
        busy_nxt = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_nxt[i] = cnt[i];
            if ((issue_valid && (issue_id == 2'(i))) && !(hit && (s_id == 2'(i)))) begin
                if (cnt[i] == CNT_MAX) begin
                    sat_err = 1'b1;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end else if (!(issue_valid && (issue_id == 2'(i))) && (hit && (s_id == 2'(i)))) begin
                cnt_nxt[i] = cnt[i] - 1'b1;
            end
            busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
        end
    end

    assign fifo_pop = evt_ready && !fifo_empty;
    assign ovf_err  = hit && fifo_full && !fifo_pop;

    always_comb begin
        err_set           = '0;
        err_set[ERR_SPUR] = s_vld && !hit;
        err_set[ERR_OVF]  = ovf_err;
        err_set[ERR_SAT]  = sat_err;
    end

    ack_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (hit),
        .push_data (s_id),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign evt_valid = !fifo_empty;
    assign evt_id    = fifo_head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_vld <= 1'b0;
            s_id  <= '0;
            busy  <= 1'b0;
            err   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s_vld <= ~ack_valid_n_bus_i;
            s_id  <= ack_id_bus_i;
            busy  <= busy_nxt;
            err   <= (err_clr ? 3'b000 : err) | err_set;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_pend
        assign pending_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
endmodule

// File: tb/tb_ack_bus_rx_tracker.sv
// tb/tb_ack_bus_rx_tracker.sv - self-checking bench for ack_bus_rx_tracker
module tb_ack_bus_rx_tracker;
    import ack_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int MAXC  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ack_valid_n_bus_i = 1'b1;
    logic [1:0]        ack_id_bus_i = '0;
    logic              issue_valid = 1'b0;
    logic [1:0]        issue_id = '0;
    logic              evt_valid;
    logic [1:0]        evt_id;
    logic              evt_ready = 1'b0;
    logic [4*CNT_W-1:0] pending_cnt;
    logic              busy;
    logic [2:0]        err;
    logic              err_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ack_bus_rx_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ack_valid_n_bus_i (ack_valid_n_bus_i),
        .ack_id_bus_i      (ack_id_bus_i),
        .issue_valid       (issue_valid),
        .issue_id          (issue_id),
        .evt_valid         (evt_valid),
        .evt_id            (evt_id),
        .evt_ready         (evt_ready),
        .pending_cnt       (pending_cnt),
        .busy              (busy),
        .err               (err),
        .err_clr           (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a queue of events and an integer count per source.
    bit        m_svld;
    bit [1:0]  m_sid;
    int        m_cnt [4];
    bit [1:0]  m_q [$];
    bit [2:0]  m_err;
    bit        chk_en = 1'b0;
    bit        m_hit;
    bit        m_pop;
    bit [2:0]  m_new;
    int        m_delta;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err  = 0;
            m_svld = 0;
            m_sid  = 0;
            chk_en = 1;
        end else begin
            m_new = 0;
            m_hit = 0;
            m_pop = (m_q.size() != 0) && evt_ready;
            if (m_svld) begin
                if (m_cnt[m_sid] > 0 || (issue_valid && issue_id == m_sid)) m_hit = 1;
                else m_new[0] = 1;
            end
            for (int i = 0; i < 4; i++) begin
                m_delta = ((issue_valid && issue_id == i) ? 1 : 0) - ((m_hit && m_sid == i) ? 1 : 0);
                if (m_delta > 0 && m_cnt[i] == MAXC) m_new[2] = 1;
                else m_cnt[i] += m_delta;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_hit) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_sid);
                else m_new[1] = 1;
            end
            m_err  = (err_clr ? 3'b000 : m_err) | m_new;
            m_svld = !ack_valid_n_bus_i;
            m_sid  = ack_id_bus_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", int'(evt_valid), int'(m_q.size() != 0));
            if (m_q.size() != 0) chk("evt_id", int'(evt_id), int'(m_q[0]));
            for (int i = 0; i < 4; i++)
                chk($sformatf("pending_cnt[%0d]", i), int'(pending_cnt[i*CNT_W +: CNT_W]), m_cnt[i]);
            chk("busy", int'(busy), int'((m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3]) != 0));
            chk("err", int'(err), int'(m_err));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack(input logic [1:0] id);
        ack_valid_n_bus_i = 1'b0;
        ack_id_bus_i      = id;
        step();
        ack_valid_n_bus_i = 1'b1;
    endtask

    task automatic issue(input logic [1:0] id, input int n);
        issue_valid = 1'b1;
        issue_id    = id;
        step(n);
        issue_valid = 1'b0;
    endtask

    initial begin
        step(2);
        rst_n = 1'b1;
        chk("lit_reset_evt_valid", int'(evt_valid), 0);
        chk("lit_reset_pending", int'(pending_cnt), 0);
        chk("lit_reset_err", int'(err), 0);

        // 1: single issue/ack latency
        issue(ID_SHA, 1);
        chk("lit_t1_pend_sha", int'(pending_cnt[3 +: 3]), 1);
        chk("lit_t1_busy1", int'(busy), 1);
        ack(ID_SHA);
        chk("lit_t1_not_yet", int'(evt_valid), 0);
        step();
        chk("lit_t1_evt_valid", int'(evt_valid), 1);
        chk("lit_t1_evt_id", int'(evt_id), 1);
        chk("lit_t1_pend_sha0", int'(pending_cnt[3 +: 3]), 0);
        chk("lit_t1_busy0", int'(busy), 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;

        // 2: ordering of back-to-back acks
        issue(ID_MEM, 1);
        issue(ID_AES, 1);
        issue(ID_CTRL, 1);
        ack(ID_AES);
        ack(ID_MEM);
        ack(ID_CTRL);
        step(2);
        chk("lit_t2_head0", int'(evt_id), 2);
        evt_ready = 1'b1;
        step();
        chk("lit_t2_head1", int'(evt_id), 0);
        step();
        chk("lit_t2_head2", int'(evt_id), 3);
        step();
        evt_ready = 1'b0;
        chk("lit_t2_empty", int'(evt_valid), 0);
        chk("lit_t2_err", int'(err), 0);

        // 3: full fifo with and without a coincident pop
        issue(ID_MEM, 6);
        repeat (5) ack(ID_MEM);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("lit_t3_no_err", int'(err), 0);
        chk("lit_t3_pend_mem1", int'(pending_cnt[0 +: 3]), 1);
        ack(ID_MEM);
        step();
        chk("lit_t3_ovf", int'(err), 3'b010);
        chk("lit_t3_pend_mem0", int'(pending_cnt[0 +: 3]), 0);
        evt_ready = 1'b1;
        step(4);
        evt_ready = 1'b0;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("lit_t3_drained", int'(evt_valid), 0);

        // 4: spurious ack and err_clr interaction
        ack(ID_AES);
        step();
        chk("lit_t4_spur", int'(err), 3'b001);
        chk("lit_t4_no_evt", int'(evt_valid), 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("lit_t4_clr", int'(err), 0);
        ack(ID_AES);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("lit_t4_set_wins", int'(err), 3'b001);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // 5: saturation, then coincident issue and ack at max
        issue(ID_MEM, 8);
        chk("lit_t5_sat_cnt", int'(pending_cnt[0 +: 3]), 7);
        chk("lit_t5_sat_err", int'(err), 3'b100);
        ack(ID_MEM);
        issue(ID_MEM, 1);
        chk("lit_t5_net_cnt", int'(pending_cnt[0 +: 3]), 7);
        chk("lit_t5_evt", int'(evt_valid), 1);
        ack(ID_MEM);
        ack(ID_MEM);
        step();
        chk("lit_t5_cnt5", int'(pending_cnt[0 +: 3]), 5);

        // 6: reset mid-operation flushes everything
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("lit_t6_evt_valid", int'(evt_valid), 0);
        chk("lit_t6_pending", int'(pending_cnt), 0);
        chk("lit_t6_err", int'(err), 0);
        chk("lit_t6_busy", int'(busy), 0);

        // same-cycle issue covers an ack at zero count; different IDs independent
        ack(ID_SHA);
        issue(ID_SHA, 1);
        chk("lit_x_evt", int'(evt_valid), 1);
        chk("lit_x_sha0", int'(pending_cnt[3 +: 3]), 0);
        ack(ID_CTRL);
        issue(ID_AES, 1);
        chk("lit_x_aes1", int'(pending_cnt[6 +: 3]), 1);
        chk("lit_x_spur", int'(err), 3'b001);
        evt_ready = 1'b1;
        step(3);
        evt_ready = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
